scr1_imem_tgt: RTL
==================

SCR1_IMEM_TGT -- requirements
Module: scr1_imem_tgt

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 1024: backing-array depth in 32-bit words; power of two, at least 4.
REQ-002 SHALL have parameter WAIT_CYCLES, default 0: extra cycles between ack and response; range 0..15.
REQ-003 SHALL have port clk, input, 1: sole clock; all state changes on posedge.
REQ-004 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have port imem_req_ack, output, 1: request accepted this cycle.
REQ-006 SHALL have port imem_req, input, 1: request valid.
REQ-007 SHALL have port imem_cmd, input, type_scr1_mem_cmd_e: command.
REQ-008 SHALL have port imem_addr, input, `SCR1_IMEM_AWIDTH: byte address.
REQ-009 SHALL have port imem_rdata, output, `SCR1_IMEM_DWIDTH: read data.
REQ-010 SHALL have port imem_resp, output, type_scr1_mem_resp_e: response status.
REQ-011 SHALL have ports ld_we (input, 1), ld_addr (input, $clog2(MEM_WORDS)), ld_wdata (input, 32): backdoor word write for program load.

Function
REQ-012 SHALL implement FSM states IDLE, WAIT and RESP.
REQ-013 SHALL drive imem_req_ack = 1 combinationally in IDLE and RESP, and 0 in WAIT.
REQ-014 SHALL accept a request when imem_req & imem_req_ack; it captures the cmd, the word index imem_addr[2 +: $clog2(MEM_WORDS)], the error flag and the array word.
REQ-015 SHALL, on accept, go to WAIT with counter = WAIT_CYCLES - 1 if WAIT_CYCLES > 0, or else go directly to RESP.
REQ-016 SHALL, in WAIT, decrement the counter each cycle and go to RESP on the cycle the counter reads 0.
REQ-017 SHALL, in RESP, drive imem_resp = RDY_OK or RDY_ER for exactly one cycle.
REQ-018 SHALL drive imem_resp = NOTRDY and imem_rdata = 0 in IDLE and WAIT.
REQ-019 SHALL set the latency from accept to response at 1 + WAIT_CYCLES cycles.
REQ-020 SHALL, in RESP with a new accept in the same cycle, restart per REQ-015; otherwise it returns to IDLE. This gives back-to-back responses every cycle when WAIT_CYCLES = 0.
REQ-021 SHALL respond RDY_ER with rdata 0 when the cmd is not SCR1_MEM_CMD_RD, or when imem_addr[1:0] != 0.
REQ-022 SHALL return on RDY_OK the array word as of the accept cycle; an ld_we to the same word in the accept cycle yields the old data.
REQ-023 SHALL commit ld_we writes at posedge in every state, independent of the FSM.
REQ-024 SHALL hold imem_rdata at 0 on RDY_ER.

Reset
REQ-025 SHALL, while rst_n is low at posedge, set the FSM to IDLE, the counter to 0, imem_resp to NOTRDY and imem_rdata to 0; imem_req_ack then evaluates to 1 on the first cycle after release.
REQ-026 SHALL abandon any in-flight transaction on reset without issuing a response.
REQ-027 SHALL leave array contents unchanged by reset.

Configuration
REQ-028 SHALL, with SCR1_IMEM_TGT_RANGE_CHECK_EN defined, respond RDY_ER to any address with byte offset >= MEM_WORDS*4 (upper address bits nonzero).
REQ-029 SHALL, without SCR1_IMEM_TGT_RANGE_CHECK_EN, ignore the upper address bits so that addresses wrap modulo MEM_WORDS*4.

Structure
REQ-030 SHALL take type_scr1_mem_cmd_e and type_scr1_mem_resp_e from the shared memory-interface header, with no local redefinition.
REQ-031 SHALL keep its FSM state enum local to the module.
REQ-032 SHALL implement the backing array as one sub-module, scr1_imem_tgt_ram, with one synchronous read port and one write port.

Verification
REQ-033 SHALL test single read: WAIT_CYCLES = 0, word 0x10 preloaded 0xDEADBEEF, RD to 0x40 -> ack in cycle T, RDY_OK and 0xDEADBEEF in T+1, NOTRDY in T+2.
REQ-034 SHALL test back-to-back reads: WAIT_CYCLES = 0, reads to 0x0, 0x4, 0x8 held continuously -> three consecutive RDY_OK cycles with ack high throughout.
REQ-035 SHALL test wait states: WAIT_CYCLES = 3 -> RDY_OK at T+4, ack low during T+1..T+3, and a second req held during WAIT is acked at T+4.
REQ-036 SHALL test error cases: WR cmd to 0x0 -> RDY_ER, rdata 0; addr 0x2 -> RDY_ER; with the macro and MEM_WORDS = 1024, addr 0x1000 -> RDY_ER; without the macro, 0x1000 returns word 0.
REQ-037 SHALL test load collision: ld_we to word 5 (0x12345678, old 0xAAAAAAAA) in the accept cycle of a read to 0x14 -> 0xAAAAAAAA returned, and a following read returns 0x12345678.
REQ-038 SHALL test reset mid-operation: WAIT_CYCLES = 5, rst_n low in cycle T+2 -> no response, state IDLE, ack high after release, array intact.

Source files
------------

// File: rtl/scr1_imem_tgt_pkg.sv
// scr1_imem_tgt_pkg: shared memory-interface command/response types and bus widths
// Provides type_scr1_mem_cmd_e, type_scr1_mem_resp_e and the `SCR1_IMEM_AWIDTH /
// `SCR1_IMEM_DWIDTH width macros used by the imem target and its interface.
`ifndef SCR1_IMEM_AWIDTH
`define SCR1_IMEM_AWIDTH 32
`endif
`ifndef SCR1_IMEM_DWIDTH
`define SCR1_IMEM_DWIDTH 32
`endif
package scr1_imem_tgt_pkg;
   typedef enum logic {
      SCR1_MEM_CMD_RD = 1'b0,
      SCR1_MEM_CMD_WR = 1'b1
   } type_scr1_mem_cmd_e;
   typedef enum logic [1:0] {
      SCR1_MEM_RESP_NOTRDY = 2'b00,
      SCR1_MEM_RESP_RDY_OK = 2'b01,
      SCR1_MEM_RESP_RDY_ER = 2'b10
   } type_scr1_mem_resp_e;
endpackage

// File: rtl/scr1_imem_tgt_if.sv
// scr1_imem_tgt_if: instruction-memory request/response bus
// Signals: imem_req/imem_cmd/imem_addr (core -> target), imem_req_ack/imem_rdata/imem_resp
// (target -> core). Modports: master (core side), slave (target side).
`ifndef SCR1_IMEM_AWIDTH
`define SCR1_IMEM_AWIDTH 32
`endif
`ifndef SCR1_IMEM_DWIDTH
`define SCR1_IMEM_DWIDTH 32
`endif
interface scr1_imem_tgt_if;
   import scr1_imem_tgt_pkg::*;
   logic                         imem_req_ack;
   logic                         imem_req;
   type_scr1_mem_cmd_e           imem_cmd;
   logic [`SCR1_IMEM_AWIDTH-1:0] imem_addr;
   logic [`SCR1_IMEM_DWIDTH-1:0] imem_rdata;
   type_scr1_mem_resp_e          imem_resp;
   modport master (input imem_req_ack, imem_rdata, imem_resp, output imem_req, imem_cmd, imem_addr);
   modport slave (output imem_req_ack, imem_rdata, imem_resp, input imem_req, imem_cmd, imem_addr);
endinterface

// File: rtl/scr1_imem_tgt_ram.sv
// scr1_imem_tgt_ram: backing word array with one synchronous read port and one write port
// Ports: clk; re_i/raddr_i/rdata_o (registered read); we_i/waddr_i/wdata_i (write).
// A read and write to the same word in one cycle returns the old contents.
module scr1_imem_tgt_ram #(
   parameter int WORDS = 1024,
   localparam int AW = $clog2(WORDS)
) (
   input  logic          clk,
   input  logic          re_i,
   input  logic [AW-1:0] raddr_i,
   output logic [31:0]   rdata_o,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [31:0]   wdata_i
);
   logic [31:0] mem_q [WORDS];
   logic [31:0] rdata_q;
   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      if (re_i) rdata_q <= mem_q[raddr_i];
   end
   assign rdata_o = rdata_q;
endmodule

// File: rtl/scr1_imem_tgt.sv
// scr1_imem_tgt: instruction-memory target model with configurable response latency
// Ports: clk, rst_n (sync, active-low); imem (scr1_imem_tgt_if.slave bus);
// ld_we/ld_addr/ld_wdata backdoor word write for program load.
// Option: define SCR1_IMEM_TGT_RANGE_CHECK_EN to answer RDY_ER for addresses beyond the
// array; otherwise upper address bits are ignored and addresses wrap.
module scr1_imem_tgt
   import scr1_imem_tgt_pkg::*;
#(
   parameter int MEM_WORDS   = 1024,
   parameter int WAIT_CYCLES = 0
) (
   input  logic                         clk,
   input  logic                         rst_n,
   scr1_imem_tgt_if.slave               imem,
   input  logic                         ld_we,
   input  logic [$clog2(MEM_WORDS)-1:0] ld_addr,
   input  logic [31:0]                  ld_wdata
);
   localparam int IW = $clog2(MEM_WORDS);
   localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        err_q, err_d;
   logic        ack, accept, addr_hi, bad;
   logic [31:0] ram_rdata;
   assign ack     = state_q != WAIT;
   assign accept  = imem.imem_req & ack;
   assign addr_hi = |(imem.imem_addr >> (IW + 2));
`ifdef SCR1_IMEM_TGT_RANGE_CHECK_EN
   assign bad = (imem.imem_cmd != SCR1_MEM_CMD_RD) | (|imem.imem_addr[1:0]) | addr_hi;
`else
   logic addr_hi_unused;
   assign addr_hi_unused = addr_hi;
   assign bad = (imem.imem_cmd != SCR1_MEM_CMD_RD) | (|imem.imem_addr[1:0]);
`endif
   // An accept in RESP restarts the sequence, giving back-to-back responses.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      if (accept) begin
         state_d = WAIT_CYCLES > 0 ? WAIT : RESP;
         cnt_d   = WAIT_INIT;
         err_d   = bad;
      end else if (state_q == WAIT) begin
         state_d = cnt_q == 4'd0 ? RESP : WAIT;
         cnt_d   = cnt_q == 4'd0 ? 4'd0 : cnt_q - 4'd1;
      end else if (state_q == RESP) begin
         state_d = IDLE;
      end
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end
   // The RAM read register captures the word at accept and holds it through WAIT.
   scr1_imem_tgt_ram #(.WORDS(MEM_WORDS)) u_ram (
      .clk     (clk),
      .re_i    (accept),
      .raddr_i (imem.imem_addr[2 +: IW]),
      .rdata_o (ram_rdata),
      .we_i    (ld_we),
      .waddr_i (ld_addr),
      .wdata_i (ld_wdata)
   );
   assign imem.imem_req_ack = ack;
   assign imem.imem_resp    = state_q != RESP ? SCR1_MEM_RESP_NOTRDY
                            : err_q ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
   assign imem.imem_rdata   = (state_q == RESP && !err_q) ? ram_rdata : '0;
endmodule
